// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, state encodings and IF/ID layout for the fetch stage
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;  // sll $0,$0,0

  localparam logic [1:0] FS_REQ  = 2'b00;
  localparam logic [1:0] FS_HOLD = 2'b01;
  localparam logic [1:0] FS_DROP = 2'b10;

  typedef enum logic [1:0] {
    S_REQ  = FS_REQ,
    S_HOLD = FS_HOLD,
    S_DROP = FS_DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc4: 32'h0, valid: 1'b0};

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_register.sv
// rtl/fetch_stage_ifid_register.sv - IF/ID pipeline register with load, flush and reset to bubble
module ifid_register
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        flush,
  input  logic [64:0] d,
  output logic [64:0] q
);

  // Flush beats load so a redirect always leaves a bubble behind it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= IFID_BUBBLE;
    end else if (flush) begin
      q <= IFID_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction-memory handshake FSM and skid buffer feeding IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ack,
  input  logic [31:0] IM_Data,
  output logic [31:0] PR_IFID_Inst,
  output logic [31:0] PR_IFID_PC4,
  output logic        PR_IFID_Valid
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc4;
  logic [31:0]  target;
  logic [31:0]  hold_inst;
  logic [31:0]  hold_pc4;
  logic         im_req;
  logic [31:0]  im_addr;

  logic         ifid_load;
  logic         ifid_flush;
  ifid_t        ifid_d;
  ifid_t        ifid_q;

  assign pc4    = pc + 32'd4;
  assign target = align_word(Redirect_Target);

  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_d     = '{inst: IM_Data, pc4: pc4, valid: 1'b1};
    if (Redirect) begin
      ifid_flush = 1'b1;
    end else begin
      case (state)
        S_REQ: begin
          if (!Stall) begin
            if (IM_Ack) ifid_load  = 1'b1;
            else        ifid_flush = 1'b1;
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            ifid_load = 1'b1;
            ifid_d    = '{inst: hold_inst, pc4: hold_pc4, valid: 1'b1};
          end
        end
        default: ifid_flush = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      im_addr   <= RESET_PC;
      im_req    <= 1'b1;
      hold_inst <= 32'h0;
      hold_pc4  <= 32'h0;
    end else if (Redirect) begin
      pc        <= target;
      hold_inst <= 32'h0;
      hold_pc4  <= 32'h0;
      im_req    <= 1'b1;
      // An unacked request must complete at its original address before the target goes out.
      if (state == S_REQ && !IM_Ack) begin
        state <= S_DROP;
      end else begin
        state   <= S_REQ;
        im_addr <= target;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (IM_Ack) begin
            pc      <= pc4;
            im_addr <= pc4;
            if (Stall) begin
              hold_inst <= IM_Data;
              hold_pc4  <= pc4;
              state     <= S_HOLD;
              im_req    <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (!Stall) begin
            state  <= S_REQ;
            im_req <= 1'b1;
          end
        end
        S_DROP: begin
          if (IM_Ack) begin
            state   <= S_REQ;
            im_addr <= pc;
          end
        end
        default: begin
          state   <= S_REQ;
          im_req  <= 1'b1;
          im_addr <= pc;
        end
      endcase
    end
  end

  ifid_register u_ifid (
    .clock (clock),
    .reset (reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign IM_Req        = im_req;
  assign IM_Addr       = im_addr;
  assign PR_IFID_Inst  = ifid_q.inst;
  assign PR_IFID_PC4   = ifid_q.pc4;
  assign PR_IFID_Valid = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage: streaming, stall, redirect, drop, reset
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ack;
  logic [31:0] IM_Data;
  logic [31:0] PR_IFID_Inst;
  logic [31:0] PR_IFID_PC4;
  logic        PR_IFID_Valid;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h8C01_0004 : {16'h1000, a[15:0]};
  endfunction

  assign IM_Data = mem_word(IM_Addr);

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .Redirect_Target (Redirect_Target),
    .IM_Req          (IM_Req),
    .IM_Addr         (IM_Addr),
    .IM_Ack          (IM_Ack),
    .IM_Data         (IM_Data),
    .PR_IFID_Inst    (PR_IFID_Inst),
    .PR_IFID_PC4     (PR_IFID_PC4),
    .PR_IFID_Valid   (PR_IFID_Valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] inst,
                            input logic [31:0] pc4, input logic valid);
    check({tag, "_inst"}, PR_IFID_Inst, inst);
    check({tag, "_pc4"}, PR_IFID_PC4, pc4);
    check({tag, "_valid"}, {31'h0, PR_IFID_Valid}, {31'h0, valid});
  endtask

  task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, "_req"}, {31'h0, IM_Req}, {31'h0, req});
    check({tag, "_addr"}, IM_Addr, addr);
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_Target = 32'h0; IM_Ack = 1'b0;
    #1;
    check_ifid("reset", 32'h0, 32'h0, 1'b0);
    check("reset_addr", IM_Addr, 32'h0);
    step(); step();
    reset = 1'b0;
    check_req("post_reset", 1'b1, 32'h0);

    // Streaming with ack tied high
    IM_Ack = 1'b1;
    step();
    check_ifid("fetch0", 32'h8C01_0004, 32'h4, 1'b1);
    check_req("fetch0", 1'b1, 32'h4);
    step();
    check_ifid("fetch4", 32'h1000_0004, 32'h8, 1'b1);
    check("fetch4_addr", IM_Addr, 32'h8);
    step();
    check_ifid("fetch8", 32'h1000_0008, 32'hC, 1'b1);

    // Stall for three cycles: 0xC buffered, no new request
    Stall = 1'b1;
    step();
    check_ifid("stall1", 32'h1000_0008, 32'hC, 1'b1);
    check("stall1_req", {31'h0, IM_Req}, 32'h0);
    step();
    check("stall2_inst", PR_IFID_Inst, 32'h1000_0008);
    check("stall2_req", {31'h0, IM_Req}, 32'h0);
    step();
    check("stall3_inst", PR_IFID_Inst, 32'h1000_0008);
    Stall = 1'b0;
    step();
    check_ifid("unstall", 32'h1000_000C, 32'h10, 1'b1);
    check_req("unstall", 1'b1, 32'h10);
    step();
    check_ifid("fetch10", 32'h1000_0010, 32'h14, 1'b1);
    step(); step(); step();
    check("at20_addr", IM_Addr, 32'h20);

    // Redirect with same-cycle ack: target bits [1:0] dropped
    Redirect = 1'b1; Redirect_Target = 32'h0000_0103;
    step();
    Redirect = 1'b0;
    check_ifid("redir_ack", 32'h0, 32'h0, 1'b0);
    check_req("redir_ack", 1'b1, 32'h100);
    step();
    check_ifid("fetch100", 32'h1000_0100, 32'h104, 1'b1);

    // Slow memory: redirect in the first wait cycle, old ack discarded
    IM_Ack = 1'b0; Redirect = 1'b1; Redirect_Target = 32'h40;
    step();
    Redirect = 1'b0;
    check_ifid("drop_enter", 32'h0, 32'h0, 1'b0);
    check_req("drop_enter", 1'b1, 32'h104);
    step();
    check("drop_wait_valid", {31'h0, PR_IFID_Valid}, 32'h0);
    check_req("drop_wait", 1'b1, 32'h104);
    IM_Ack = 1'b1;
    step();
    check_ifid("drop_ack", 32'h0, 32'h0, 1'b0);
    check_req("drop_ack", 1'b1, 32'h40);
    step();
    check_ifid("fetch40", 32'h1000_0040, 32'h44, 1'b1);

    // Redirect and stall together while a word is buffered
    Stall = 1'b1;
    step();
    check("hold_req", {31'h0, IM_Req}, 32'h0);
    check("hold_inst", PR_IFID_Inst, 32'h1000_0040);
    Redirect = 1'b1; Redirect_Target = 32'h80;
    step();
    Redirect = 1'b0; Stall = 1'b0;
    check_ifid("hold_redir", 32'h0, 32'h0, 1'b0);
    check_req("hold_redir", 1'b1, 32'h80);
    step();
    check_ifid("fetch80", 32'h1000_0080, 32'h84, 1'b1);

    // Reset asserted mid-stall clears IF/ID immediately
    Stall = 1'b1;
    step();
    check("pre_reset_req", {31'h0, IM_Req}, 32'h0);
    reset = 1'b1;
    #1;
    check_ifid("async_reset", 32'h0, 32'h0, 1'b0);
    step();
    reset = 1'b0; Stall = 1'b0;
    check_req("reset_release", 1'b1, 32'h0);
    step();
    check_ifid("refetch0", 32'h8C01_0004, 32'h4, 1'b1);

    // PC+4 wraps from the last word
    Redirect = 1'b1; Redirect_Target = 32'hFFFF_FFFF;
    step();
    Redirect = 1'b0;
    check_req("wrap_redir", 1'b1, 32'hFFFF_FFFC);
    step();
    check_ifid("wrap_fetch", 32'h1000_FFFC, 32'h0, 1'b1);
    check("wrap_addr", IM_Addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
